serial_comparator: RTL and testbench
====================================

Name: serial_comparator

Overview:
Sequential, parametrised magnitude comparator with start/busy/done handshake. Scans operands MSB-first, `step` bits per clock, and terminates at the first differing chunk.
Supports unsigned and two's-complement compare, selected per operation. Used where wide operands make a single-cycle compare too slow, or where comparator area must be shared over several cycles.

Parameters:
size, 8, operand width in bits; size >= 2.
step, 1, bits examined per SCAN cycle; size % step == 0 is required (elaboration error otherwise).

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start
a  input  size  operand A; latched with start
b  input  size  operand B; latched with start
busy  output  1  high while in SCAN
done  output  1  one-cycle pulse: result is valid
a_gt_b  output  1  registered result, A > B
a_lt_b  output  1  registered result, A < B
a_eq_b  output  1  registered result, A == B

Behaviour:
- Reset (asynchronous, active-high; any state, including mid-SCAN):
  - state = IDLE
  - busy = 0, done = 0
  - a_gt_b = a_lt_b = a_eq_b = 0
  - chunk counter = 0
  - operand registers cleared
- States: IDLE, SCAN, DONE.
- IDLE:
  - On a clock edge with start = 1: capture a, b and signed_mode; counter = N-1 (N = size/step); go to SCAN.
  - Signed handling: if signed_mode = 1, invert bit size-1 of both captured operands at load. This converts to offset binary, so the scan is always an unsigned compare.
  - Results keep their previous values until the next decision.
- SCAN (busy = 1):
  - Each edge compares captured chunk [counter*step+step-1 : counter*step] of A and B as unsigned numbers.
  - If the chunks differ: a_gt_b = (A chunk > B chunk), a_lt_b = its complement, a_eq_b = 0; go to DONE.
  - Else if counter == 0: a_gt_b = 0, a_lt_b = 0, a_eq_b = 1; go to DONE.
  - Else: counter decrements and the FSM stays in SCAN.
- DONE:
  - done = 1, busy = 0, for exactly one cycle; next edge returns to IDLE.
- Latency:
  - The start edge is edge 0.
  - done is high in the cycle after edge k, where k = 1-based position from the MSB of the first differing chunk, or N if the operands are equal.
  - Minimum latency is 1; maximum is N.
- Start handling: start is ignored in SCAN and DONE (no queueing). Back-to-back operations therefore need start re-asserted in IDLE, giving throughput of one compare per k+2 cycles.
- Result outputs are one-hot (exactly one set) after any completed operation. They are all zero only after reset, before the first completion.
- Operand inputs may change freely after the start edge; only the captured values are used.

Optional Feature:
Macro CMP_CONST_LATENCY_EN.
- Defined: early termination is disabled.
  - SCAN always runs all N chunks.
  - The first differing chunk's verdict is held in an internal sticky flag; later chunks cannot override it.
  - Outputs and done update only at the counter == 0 edge.
  - done always appears N cycles after the start edge, giving data-independent timing.
- Undefined: early-terminating behaviour as above.
- Result values are identical in both builds.

Test Plan:
1. size=8, step=1, unsigned, a=8'hA5, b=8'h25, start -> done high 1 cycle after start edge; a_gt_b=1, a_lt_b=0, a_eq_b=0; busy high for exactly 1 cycle.
2. size=8, step=1, a=b=8'h3C -> done after 8 cycles; a_eq_b=1, others 0; busy high 8 cycles.
3. size=8, a=8'hFF, b=8'h01 -> with signed_mode=1: a_lt_b=1 after 1 cycle; rerun with signed_mode=0: a_gt_b=1.
4. size=8, step=2, a=8'h04, b=8'h08 -> third chunk ([3:2] 01 vs 10) decides; done 3 cycles after start; a_lt_b=1.
5. Start a=8'h01, b=8'h00 (step=1), then:
   - Pulse start with a=8'h00, b=8'h01 during SCAN -> ignored; result a_gt_b=1 at cycle 8.
   - New run: assert reset at cycle 4 -> busy, done and all results 0 immediately (no clock needed); FSM in IDLE; a fresh start then completes normally.
6. Build with CMP_CONST_LATENCY_EN, step=1, a=8'h80, b=8'h00 -> done exactly 8 cycles after start; a_gt_b=1; outputs unchanged (still previous values) before that edge.

Source files
------------

// File: rtl/serial_comparator.sv
// serial_comparator
//   Sequential magnitude comparator with a start/busy/done handshake.
//   Operands are scanned MSB-first, `step` bits per clock. By default the
//   scan stops at the first differing chunk.
//
//   Optional build macro: CMP_CONST_LATENCY_EN
//     When defined, every compare takes all size/step chunks, so the timing
//     does not depend on the data. The results are the same as in the
//     default build.
//
// Parameters
//   size : operand width in bits (size >= 2)
//   step : bits examined per SCAN cycle (size % step == 0)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   start       in   request; sampled only in IDLE
//   signed_mode in   1 = two's-complement compare, 0 = unsigned; latched with start
//   a, b        in   operands; latched with start
//   busy        out  high while scanning
//   done        out  one-cycle pulse; results valid
//   a_gt_b      out  registered result, A > B
//   a_lt_b      out  registered result, A < B
//   a_eq_b      out  registered result, A == B
module serial_comparator #(
  parameter int unsigned size = 8,
  parameter int unsigned step = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            a_gt_b,
  output logic            a_lt_b,
  output logic            a_eq_b
);

  localparam int unsigned chunks = size / step;
  localparam int unsigned cnt_w  = (chunks > 1) ? $clog2(chunks) : 1;

  if (size < 2 || step == 0 || (size % step) != 0) begin : g_param_check
    $error("serial_comparator: size must be >= 2 and a multiple of step");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [cnt_w-1:0]  cnt;
  logic [size-1:0]   a_q;
  logic [size-1:0]   b_q;

  logic [size-1:0]   a_shift;
  logic [size-1:0]   b_shift;
  logic [step-1:0]   a_chunk;
  logic [step-1:0]   b_chunk;
  logic              chunk_diff;
  logic              chunk_gt;
  logic              last_chunk;

`ifdef CMP_CONST_LATENCY_EN
  // Verdict of the first differing chunk. Later chunks must not override it.
  logic              decided;
  logic              decided_gt;
`endif

  // Select the chunk under the counter. Shifting first keeps the part-select
  // constant.
  always_comb begin
    a_shift    = a_q >> (cnt * step);
    b_shift    = b_q >> (cnt * step);
    a_chunk    = a_shift[step-1:0];
    b_chunk    = b_shift[step-1:0];
    chunk_diff = (a_chunk != b_chunk);
    chunk_gt   = (a_chunk > b_chunk);
    last_chunk = (cnt == '0);
  end

  always_comb begin
    busy = (state == SCAN);
    done = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      a_gt_b <= 1'b0;
      a_lt_b <= 1'b0;
      a_eq_b <= 1'b0;
`ifdef CMP_CONST_LATENCY_EN
      decided    <= 1'b0;
      decided_gt <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's complement onto offset binary.
            // The scan is then always an unsigned compare.
            a_q   <= {a[size-1] ^ signed_mode, a[size-2:0]};
            b_q   <= {b[size-1] ^ signed_mode, b[size-2:0]};
            cnt   <= cnt_w'(chunks - 1);
            state <= SCAN;
`ifdef CMP_CONST_LATENCY_EN
            decided    <= 1'b0;
            decided_gt <= 1'b0;
`endif
          end
        end

        SCAN: begin
`ifdef CMP_CONST_LATENCY_EN
          if (last_chunk) begin
            state <= DONE;
            if (decided) begin
              a_gt_b <= decided_gt;
              a_lt_b <= ~decided_gt;
              a_eq_b <= 1'b0;
            end else if (chunk_diff) begin
              a_gt_b <= chunk_gt;
              a_lt_b <= ~chunk_gt;
              a_eq_b <= 1'b0;
            end else begin
              a_gt_b <= 1'b0;
              a_lt_b <= 1'b0;
              a_eq_b <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
            if (!decided && chunk_diff) begin
              decided    <= 1'b1;
              decided_gt <= chunk_gt;
            end
          end
`else
          if (chunk_diff) begin
            a_gt_b <= chunk_gt;
            a_lt_b <= ~chunk_gt;
            a_eq_b <= 1'b0;
            state  <= DONE;
          end else if (last_chunk) begin
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator
//   Directed bench for serial_comparator. It uses two instances: step=1 and
//   step=2, both with size=8. Expected results and latencies are pushed to
//   a scoreboard queue when a request is driven. They are popped and compared
//   when done is seen.
module tb_serial_comparator;

  logic       clock = 1'b0;
  logic       reset;
  logic       start1, start2;
  logic       signed_mode;
  logic [7:0] a, b;

  logic busy1, done1, gt1, lt1, eq1;
  logic busy2, done2, gt2, lt2, eq2;

  serial_comparator #(.size(8), .step(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1),
    .a_gt_b(gt1), .a_lt_b(lt1), .a_eq_b(eq1)
  );

  serial_comparator #(.size(8), .step(2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy2), .done(done2),
    .a_gt_b(gt2), .a_lt_b(lt2), .a_eq_b(eq2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] res;  // {gt, lt, eq}
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] prev_res [2];

  function automatic logic [2:0] res_of(int sel);
    return (sel == 1) ? {gt1, lt1, eq1} : {gt2, lt2, eq2};
  endfunction

  function automatic logic done_of(int sel);
    return (sel == 1) ? done1 : done2;
  endfunction

  function automatic logic busy_of(int sel);
    return (sel == 1) ? busy1 : busy2;
  endfunction

  task automatic set_start(int sel, logic v);
    if (sel == 1) start1 = v;
    else          start2 = v;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: full-width compare, plus a search for the first
  // differing chunk from the MSB.
  function automatic exp_t model(int sel, logic [7:0] av, logic [7:0] bv, logic sm);
    exp_t e;
    int   st;
    int   nch;
    logic found;
    logic gt;
    st    = (sel == 1) ? 1 : 2;
    nch   = 8 / st;
    gt    = sm ? ($signed(av) > $signed(bv)) : (av > bv);
    e.res = (av == bv) ? 3'b001 : (gt ? 3'b100 : 3'b010);
    e.lat = nch;
    found = 1'b0;
    for (int i = nch - 1; i >= 0; i--) begin
      if (!found && (((av ^ bv) >> (i * st)) & ((8'd1 << st) - 8'd1)) != 0) begin
        found = 1'b1;
        e.lat = nch - i;
      end
    end
`ifdef CMP_CONST_LATENCY_EN
    e.lat = nch;
`endif
    return e;
  endfunction

  // One operation. The start edge is edge 0. If glitch >= 0, start is pulsed
  // again with different operands after that many scan cycles. That pulse
  // must be ignored.
  task automatic run_op(int sel, logic [7:0] av, logic [7:0] bv, logic sm, int glitch);
    exp_t e;
    int   cycles;
    int   busy_cnt;
    sb.push_back(model(sel, av, bv, sm));
    @(negedge clock);
    a = av; b = bv; signed_mode = sm;
    set_start(sel, 1'b1);
    @(posedge clock);
    @(negedge clock);
    set_start(sel, 1'b0);
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    cycles   = 0;
    busy_cnt = 0;
    while (!done_of(sel) && cycles < 64) begin
      check("result_hold", 32'(res_of(sel)), 32'(prev_res[sel-1]));
      if (busy_of(sel)) busy_cnt++;
      if (cycles == glitch) begin
        a = 8'h00; b = 8'h01;
        set_start(sel, 1'b1);
      end else begin
        set_start(sel, 1'b0);
      end
      @(posedge clock);
      cycles++;
      @(negedge clock);
    end
    set_start(sel, 1'b0);
    e = sb.pop_front();
    check("done_seen", 32'(done_of(sel)), 32'd1);
    check("latency", 32'(cycles), 32'(e.lat));
    check("result", 32'(res_of(sel)), 32'(e.res));
    check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
    check("busy_at_done", 32'(busy_of(sel)), 32'd0);
    prev_res[sel-1] = e.res;
    @(posedge clock);
    @(negedge clock);
    check("done_pulse", 32'(done_of(sel)), 32'd0);
    check("idle_after", 32'(busy_of(sel)), 32'd0);
    check("result_kept", 32'(res_of(sel)), 32'(e.res));
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    signed_mode = 1'b0; a = '0; b = '0;
    prev_res[0] = '0; prev_res[1] = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_res1", 32'({gt1, lt1, eq1}), 32'd0);
    check("rst_res2", 32'({gt2, lt2, eq2}), 32'd0);
    reset = 1'b0;

    run_op(1, 8'hA5, 8'h25, 1'b0, -1);   // MSB decides: gt, latency 1
    run_op(1, 8'h3C, 8'h3C, 1'b0, -1);   // equal: full scan
    run_op(1, 8'hFF, 8'h01, 1'b1, -1);   // signed -1 < 1
    run_op(1, 8'hFF, 8'h01, 1'b0, -1);   // unsigned 255 > 1
    run_op(2, 8'h04, 8'h08, 1'b0, -1);   // third 2-bit chunk decides
    run_op(2, 8'h80, 8'h7F, 1'b1, -1);   // signed -128 < 127
    run_op(1, 8'h01, 8'h00, 1'b0, 3);    // LSB decides; start during SCAN ignored

    // Reset in the middle of a scan
    @(negedge clock);
    a = 8'h01; b = 8'h00; signed_mode = 1'b0; start1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start1 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("mid_scan_busy", 32'(busy1), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_busy", 32'(busy1), 32'd0);
    check("async_done", 32'(done1), 32'd0);
    check("async_res1", 32'({gt1, lt1, eq1}), 32'd0);
    check("async_res2", 32'({gt2, lt2, eq2}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    prev_res[0] = '0; prev_res[1] = '0;

    run_op(1, 8'h01, 8'h00, 1'b0, -1);   // fresh start after reset
    run_op(1, 8'h80, 8'h00, 1'b0, -1);   // MSB decides
    run_op(1, 8'h80, 8'h00, 1'b1, -1);   // signed -128 < 0
    run_op(2, 8'h5A, 8'h5A, 1'b1, -1);   // signed equal
    run_op(2, 8'h03, 8'h02, 1'b0, -1);   // last 2-bit chunk decides

    for (int i = 0; i < 8; i++) begin
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), -1);
      run_op(2, 8'($urandom), 8'($urandom), 1'($urandom), -1);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
